// File: rtl/arith_pkg.sv
// Shared single-bit arithmetic helpers and defaults for the leaf arithmetic primitives.
package arith_pkg;

  localparam logic FS_BORROW_RST = 1'b0;

  typedef struct packed {
    logic d;
    logic bo;
  } fs_res_t;

  function automatic logic fs_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  function automatic fs_res_t fs_eval(input logic a, input logic b, input logic bin);
    fs_res_t r;
    r.d  = fs_diff(a, b, bin);
    r.bo = fs_borrow(a, b, bin);
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Purely combinational single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_cell
  import arith_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bo_o
);

  fs_res_t res;

  always_comb begin
    res  = fs_eval(a_i, b_i, bin_i);
    d_o  = res.d;
    bo_o = res.bo;
  end

endmodule

// File: rtl/full_subtractor.sv
// Full subtractor with optional bit-serial chaining through an internal borrow register,
// registered or combinational result outputs, and a registered valid flag.
module full_subtractor
  import arith_pkg::*;
#(
  parameter bit   REG_OUT    = 1'b1,
  parameter logic BORROW_RST = FS_BORROW_RST
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic in_valid,
  input  logic chain_en,
  input  logic first,
  output logic d,
  output logic bo,
  output logic out_valid
);

  logic bin;
  logic cell_d;
  logic cell_bo;
  logic borrow_q;
  logic borrow_d;
  logic valid_q;

  // The chained borrow is only used mid-word; the first bit of a word restarts from c.
  always_comb begin
    bin = c;
    if (chain_en && !first) begin
      bin = borrow_q;
    end
  end

  full_subtractor_cell u_cell (
    .a_i   (a),
    .b_i   (b),
    .bin_i (bin),
    .d_o   (cell_d),
    .bo_o  (cell_bo)
  );

  always_comb begin
    borrow_d = borrow_q;
    if (in_valid) begin
      borrow_d = cell_bo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      borrow_q <= BORROW_RST;
      valid_q  <= 1'b0;
    end else begin
      borrow_q <= borrow_d;
      valid_q  <= in_valid;
    end
  end

  assign out_valid = valid_q;

  generate
    if (REG_OUT) begin : g_reg_out
      logic d_q;
      logic d_d;
      logic bo_q;
      logic bo_d;

      always_comb begin
        d_d  = d_q;
        bo_d = bo_q;
        if (in_valid) begin
          d_d  = cell_d;
          bo_d = cell_bo;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_q  <= 1'b0;
          bo_q <= 1'b0;
        end else begin
          d_q  <= d_d;
          bo_q <= bo_d;
        end
      end

      assign d  = d_q;
      assign bo = bo_q;
    end else begin : g_comb_out
      // Outputs are still forced low while reset is held so reset behaves the same in both builds.
      assign d  = rst ? 1'b0 : cell_d;
      assign bo = rst ? 1'b0 : cell_bo;
    end
  endgenerate

endmodule

// File: tb/tb_full_subtractor.sv
// Directed self-checking bench for full_subtractor in registered and combinational builds.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;
  logic in_valid = 1'b0;
  logic chain_en = 1'b0;
  logic first = 1'b0;

  logic d_r, bo_r, ov_r;
  logic d_c, bo_c, ov_c;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  full_subtractor #(.REG_OUT(1'b1), .BORROW_RST(1'b0)) u_reg (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .chain_en  (chain_en),
    .first     (first),
    .d         (d_r),
    .bo        (bo_r),
    .out_valid (ov_r)
  );

  full_subtractor #(.REG_OUT(1'b0), .BORROW_RST(1'b0)) u_comb (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .chain_en  (chain_en),
    .first     (first),
    .d         (d_c),
    .bo        (bo_c),
    .out_valid (ov_c)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic drive(input logic ai, input logic bi, input logic ci,
                       input logic vi, input logic ce, input logic fi);
    a = ai; b = bi; c = ci; in_valid = vi; chain_en = ce; first = fi;
  endtask

  // Drive one input beat, clock it, and sample the registered build 1 time unit after the edge.
  task automatic step(input logic ai, input logic bi, input logic ci,
                      input logic vi, input logic ce, input logic fi);
    drive(ai, bi, ci, vi, ce, fi);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ed, input logic ebo, input logic eov);
    chk({tag, "_d"}, d_r, ed);
    chk({tag, "_bo"}, bo_r, ebo);
    chk({tag, "_ov"}, ov_r, eov);
  endtask

  logic [1:0] exp_tab [8];
  logic [3:0] wa, wb, wd;

  initial begin
    exp_tab[0] = 2'b00; exp_tab[1] = 2'b11; exp_tab[2] = 2'b11; exp_tab[3] = 2'b01;
    exp_tab[4] = 2'b10; exp_tab[5] = 2'b00; exp_tab[6] = 2'b00; exp_tab[7] = 2'b11;

    // Reset state
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_comb_ov", ov_c, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational build: result visible before the clock edge, valid one cycle later
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("comb_d_same_cycle", d_c, 1'b1);
    chk("comb_bo_same_cycle", bo_c, 1'b1);
    chk("comb_ov_before_edge", ov_c, 1'b0);
    chk("reg_d_before_edge", d_r, 1'b0);
    @(posedge clk);
    #1;
    chk("comb_ov_after_edge", ov_c, 1'b1);
    chk_out("reg_after_comb_test", 1'b1, 1'b1, 1'b1);

    // Full truth table, chain_en=0
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(v[2], v[1], v[0], 1'b1, 1'b0, 1'b0);
      chk_out($sformatf("tt%0d", i), exp_tab[i][1], exp_tab[i][0], 1'b1);
    end

    // Serial 5 - 3 = 2, LSB first
    wa = 4'd5; wb = 4'd3; wd = 4'd2;
    for (int i = 0; i < 4; i++) begin
      step(wa[i], wb[i], 1'b0, 1'b1, 1'b1, (i == 0));
      chk({"s53_bit", 8'(48 + i)}, d_r, wd[i]);
      chk({"s53_ov", 8'(48 + i)}, ov_r, 1'b1);
    end
    chk("s53_final_bo", bo_r, 1'b0);

    // Serial 3 - 5 = 14 (mod 16), final borrow set
    wa = 4'd3; wb = 4'd5; wd = 4'd14;
    for (int i = 0; i < 4; i++) begin
      step(wa[i], wb[i], 1'b0, 1'b1, 1'b1, (i == 0));
      chk({"s35_bit", 8'(48 + i)}, d_r, wd[i]);
    end
    chk("s35_final_bo", bo_r, 1'b1);

    // Serial 5 - 3 again with idle gaps carrying misleading inputs between bits
    wa = 4'd5; wb = 4'd3; wd = 4'd2;
    for (int i = 0; i < 4; i++) begin
      logic hd, hbo;
      step(wa[i], wb[i], 1'b0, 1'b1, 1'b1, (i == 0));
      chk({"gap_bit", 8'(48 + i)}, d_r, wd[i]);
      hd = d_r; hbo = bo_r;
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk({"gap_ov", 8'(48 + i)}, ov_r, 1'b0);
      chk({"gap_hold_d", 8'(48 + i)}, d_r, hd);
      chk({"gap_hold_bo", 8'(48 + i)}, bo_r, hbo);
    end
    chk("gap_final_bo", bo_r, 1'b0);

    // Async reset mid-word while borrow is set: 3 - 5, bits 0..2 leave bo=1
    wa = 4'd3; wb = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step(wa[i], wb[i], 1'b0, 1'b1, 1'b1, (i == 0));
    end
    chk_out("pre_rst", 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 1'b0);
    chk("async_rst_comb_d", d_c, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Chained bit with first=0 right after reset must use borrow 0, ignoring c
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_out("post_rst_chain", 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
